uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, line levels
// and frame length. TX_PARITY_EN adds an even-parity bit before the stop bit.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Bits per frame including start, optional parity and stop.
    function automatic int frame_bits(input int data_bits);
`ifdef TX_PARITY_EN
        return data_bits + 3;
`else
        return data_bits + 2;
`endif
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and pulses tick_o on the last one.
// clr_i restarts the count so every FSM state gets whole bit periods.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, LSB first, registered outputs.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_pi,
    output logic                 tx_so,
    output logic                 tx_busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic                   start_q;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   so_q, so_d;
    logic                   busy_q, busy_d;
    logic                   start_edge;
    logic                   tick;
`ifdef TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign start_edge = tx_start & ~start_q;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_d != state_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: if (start_edge) begin
                shreg_d   = tx_pi;
                bit_cnt_d = '0;
`ifdef TX_PARITY_EN
                par_d     = ^tx_pi;
`endif
                state_d   = ST_START;
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: if (tick) begin
                shreg_d = shreg_q >> 1;
                if (bit_cnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP: if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output levels follow the next state so they change on the same edge as the FSM.
    always_comb begin
        so_d = IDLE_LVL;
        case (state_d)
            ST_START:  so_d = START_LVL;
            ST_DATA:   so_d = shreg_d[0];
`ifdef TX_PARITY_EN
            ST_PARITY: so_d = par_d;
`endif
            ST_STOP:   so_d = STOP_LVL;
            default:   so_d = IDLE_LVL;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            so_q      <= IDLE_LVL;
            busy_q    <= 1'b0;
`ifdef TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= tx_start;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            so_q      <= so_d;
            busy_q    <= busy_d;
`ifdef TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_so   = so_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor
// decodes the serial line cycle by cycle. Honours TX_PARITY_EN.
module tb_uart_tx;

    localparam int C  = 2;
    localparam int DB = 8;
`ifdef TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif

    typedef struct {
        logic [DB-1:0] data;
        int            rise;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_start = 1'b0;
    logic [DB-1:0] tx_pi = '0;
    logic          tx_so;
    logic          tx_busy;

    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    exp_t sbq[$];

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_pi    (tx_pi),
        .tx_so    (tx_so),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Monitor: expected line levels come from the frame definition, one entry per bit.
    int   lvl[0:NB-1];
    bit   active = 0;
    bit   prev_busy = 0;
    int   k = 0;
    exp_t it;

    always @(negedge clk) begin
        if (!rst_n) begin
            active    = 0;
            prev_busy = 0;
            chk("rst_so", tx_so, 1);
            chk("rst_busy", tx_busy, 0);
        end else begin
            if (tx_busy && !prev_busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    it = sbq.pop_front();
                    chk("latency", ncyc, it.rise);
                    lvl[0] = 0;
                    for (int i = 0; i < DB; i++) lvl[1+i] = int'(it.data[i]);
`ifdef TX_PARITY_EN
                    lvl[DB+1] = int'(^it.data);
`endif
                    lvl[NB-1] = 1;
                    active = 1;
                    k = 0;
                end
            end
            if (active) begin
                if (tx_busy && k < NB*C) begin
                    chk($sformatf("bit%0d_data%02h", k / C, it.data), tx_so, lvl[k / C]);
                    k++;
                end else if (tx_busy) begin
                    chk("frame_too_long", k + 1, NB*C);
                    active = 0;
                end else begin
                    chk("frame_len", k, NB*C);
                    active = 0;
                    chk("idle_so", tx_so, 1);
                end
            end else if (!tx_busy) begin
                chk("idle_so", tx_so, 1);
            end
            prev_busy = tx_busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) chk("idle_timeout", 1, 0);
    endtask

    // Launch one accepted frame; optionally scramble tx_pi and re-pulse start while busy.
    task automatic launch(input logic [DB-1:0] d, input int hold, input bit chg,
                          input logic [DB-1:0] chg_val, input bit repulse);
        @(negedge clk);
        tx_pi    = d;
        tx_start = 1'b1;
        sbq.push_back('{data: d, rise: ncyc + 1});
        repeat (hold) @(negedge clk);
        tx_start = 1'b0;
        if (chg) begin
            repeat (2) @(negedge clk);
            tx_pi = chg_val;
        end
        if (repulse) begin
            repeat (2) @(negedge clk);
            tx_pi    = ~d;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        launch(8'hAC, 5, 1'b1, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        launch(8'hDC, 1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        launch(8'h5A, 1, 1'b0, 8'h00, 1'b1);
        repeat (6) @(negedge clk);

        // Reset in the middle of the data bits.
        @(negedge clk);
        tx_pi    = 8'h3C;
        tx_start = 1'b1;
        sbq.push_back('{data: 8'h3C, rise: ncyc + 1});
        @(negedge clk);
        tx_start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_so", tx_so, 1);
        chk("async_rst_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        launch(8'h96, 2, 1'b0, 8'h00, 1'b0);

        for (int f = 0; f < 16; f++) begin
            launch(8'($urandom), int'($urandom_range(1, 4)), 1'($urandom),
                   8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
